// File: rtl/cr_xp10_decomp_ob_ftr_fixup.sv
// cr_xp10_decomp_ob_ftr_fixup
// Output-side stage behind the XP10 decompressor core. It registers the
// AXI4-stream through a main register plus one skid register and counts
// decompressed DATA TLV payload bytes per frame. It overwrites bytes_out
// (upper 32 bits of FTR word FTR_PATCH_WORD) with that count, and pulses
// olimit_err when a frame first grows past sw_olimit.
// Optional build macro: CR_XP10_DECOMP_OB_FTR_STATS_EN adds per-frame
// statistics outputs (frame done pulse, frame byte total, patch count).

module cr_xp10_decomp_ob_ftr_fixup #(
  parameter int         DATA_W         = 64,
  parameter logic [7:0] TLV_DATA_TYPE  = 8'h0C,
  parameter logic [7:0] TLV_FTR_TYPE   = 8'h0F,
  parameter int         FTR_PATCH_WORD = 12
) (
  input  logic                  clk,
  input  logic                  rst_sync_n,

  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic [DATA_W-1:0]     in_tdata,
  input  logic [DATA_W/8-1:0]   in_tstrb,
  input  logic [7:0]            in_tuser,
  input  logic                  in_tid,
  input  logic                  in_tlast,

  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [DATA_W-1:0]     out_tdata,
  output logic [DATA_W/8-1:0]   out_tstrb,
  output logic [7:0]            out_tuser,
  output logic                  out_tid,
  output logic                  out_tlast,

  input  logic                  sw_bypass,
  input  logic [23:0]           sw_olimit,
  output logic                  olimit_err
`ifdef CR_XP10_DECOMP_OB_FTR_STATS_EN
  ,
  output logic                  stat_frame_done,
  output logic [31:0]           stat_frame_bytes,
  output logic [15:0]           stat_patch_cnt
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WORD_W = DATA_W + STRB_W + 8 + 1 + 1;
  localparam int POP_W  = $clog2(STRB_W + 1);

  // Buffered word layout: {last, id, user, strb, data}
  logic [WORD_W-1:0] main_word_q, main_word_d;
  logic [WORD_W-1:0] skid_word_q, skid_word_d;
  logic              out_valid_q, out_valid_d;
  logic              skid_full_q, skid_full_d;
  logic              in_tready_q, in_tready_d;

  logic [3:0]        word_idx_q,  word_idx_d;
  logic [7:0]        cur_type_q,  cur_type_d;
  logic [31:0]       byte_cnt_q,  byte_cnt_d;
  logic              lim_fired_q, lim_fired_d;
  logic              olimit_err_q, olimit_err_d;

  logic              acc;
  logic              sot;
  logic              eot;
  logic [3:0]        eff_idx;
  logic [7:0]        eff_type;
  logic [POP_W-1:0]  pop_cnt;
  logic [32:0]       cnt_sum;
  logic [31:0]       cnt_upd;
  logic              is_data_payload;
  logic              frame_end;
  logic              patch;
  logic              lim_hit;
  logic [DATA_W-1:0] in_data_fix;
  logic [WORD_W-1:0] in_word;

  assign acc = in_tvalid && in_tready_q;
  assign sot = in_tuser[0];
  assign eot = in_tuser[1];

  // Per-word TLV tracking, byte count, patch and limit decisions for the word at the input
  always_comb begin
    eff_idx  = sot ? 4'd0 : ((word_idx_q == 4'd15) ? 4'd15 : word_idx_q + 4'd1);
    eff_type = sot ? in_tdata[7:0] : cur_type_q;

    pop_cnt = '0;
    for (int i = 0; i < STRB_W; i++) begin
      pop_cnt = pop_cnt + POP_W'(in_tstrb[i]);
    end

    is_data_payload = (eff_type == TLV_DATA_TYPE) && (eff_idx != 4'd0);
    cnt_sum         = {1'b0, byte_cnt_q} + 33'(pop_cnt);
    if (!is_data_payload) begin
      cnt_upd = byte_cnt_q;
    end else if (cnt_sum[32]) begin
      cnt_upd = 32'hFFFF_FFFF;
    end else begin
      cnt_upd = cnt_sum[31:0];
    end

    frame_end = (eff_type == TLV_FTR_TYPE) && eot;
    // A single-word FTR TLV is a frame end only; it never gets patched.
    patch     = (eff_type == TLV_FTR_TYPE) && (eff_idx == 4'(FTR_PATCH_WORD)) &&
                !sw_bypass && !(sot && eot);
    lim_hit   = (sw_olimit != 24'd0) && (cnt_upd > {8'd0, sw_olimit}) && !lim_fired_q;

    in_data_fix = in_tdata;
    if (patch) begin
      in_data_fix[63:32] = cnt_upd;
    end
    in_word = {in_tlast, in_tid, in_tuser, in_tstrb, in_data_fix};

    word_idx_d   = word_idx_q;
    cur_type_d   = cur_type_q;
    byte_cnt_d   = byte_cnt_q;
    lim_fired_d  = lim_fired_q;
    olimit_err_d = 1'b0;
    if (acc) begin
      word_idx_d   = eff_idx;
      cur_type_d   = eff_type;
      byte_cnt_d   = frame_end ? 32'd0 : cnt_upd;
      olimit_err_d = lim_hit;
      if (frame_end) begin
        lim_fired_d = 1'b0;
      end else if (lim_hit) begin
        lim_fired_d = 1'b1;
      end
    end
  end

  // Main/skid buffer: the skid entry always refills the main register before new input is taken
  always_comb begin
    main_word_d = main_word_q;
    skid_word_d = skid_word_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;

    if (skid_full_q) begin
      if (out_tready || !out_valid_q) begin
        main_word_d = skid_word_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end
    end else if (acc) begin
      if (out_tready || !out_valid_q) begin
        main_word_d = in_word;
        out_valid_d = 1'b1;
      end else begin
        skid_word_d = in_word;
        skid_full_d = 1'b1;
      end
    end else if (out_tready) begin
      out_valid_d = 1'b0;
    end

    in_tready_d = !skid_full_d;
  end

  // State registers; reset discards both buffer entries and all frame tracking
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      main_word_q  <= '0;
      skid_word_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_full_q  <= 1'b0;
      in_tready_q  <= 1'b0;
      word_idx_q   <= 4'd0;
      cur_type_q   <= 8'd0;
      byte_cnt_q   <= 32'd0;
      lim_fired_q  <= 1'b0;
      olimit_err_q <= 1'b0;
    end else begin
      main_word_q  <= main_word_d;
      skid_word_q  <= skid_word_d;
      out_valid_q  <= out_valid_d;
      skid_full_q  <= skid_full_d;
      in_tready_q  <= in_tready_d;
      word_idx_q   <= word_idx_d;
      cur_type_q   <= cur_type_d;
      byte_cnt_q   <= byte_cnt_d;
      lim_fired_q  <= lim_fired_d;
      olimit_err_q <= olimit_err_d;
    end
  end

  assign in_tready  = in_tready_q;
  assign out_tvalid = out_valid_q;
  assign out_tdata  = main_word_q[DATA_W-1:0];
  assign out_tstrb  = main_word_q[DATA_W +: STRB_W];
  assign out_tuser  = main_word_q[DATA_W+STRB_W +: 8];
  assign out_tid    = main_word_q[DATA_W+STRB_W+8];
  assign out_tlast  = main_word_q[WORD_W-1];
  assign olimit_err = olimit_err_q;

`ifdef CR_XP10_DECOMP_OB_FTR_STATS_EN
  logic        stat_frame_done_q,  stat_frame_done_d;
  logic [31:0] stat_frame_bytes_q, stat_frame_bytes_d;
  logic [15:0] stat_patch_cnt_q,   stat_patch_cnt_d;

  // Frame statistics: byte total captured at each frame end, wrapping patch counter
  always_comb begin
    stat_frame_done_d  = acc && frame_end;
    stat_frame_bytes_d = stat_frame_bytes_q;
    stat_patch_cnt_d   = stat_patch_cnt_q;
    if (acc && frame_end) begin
      stat_frame_bytes_d = cnt_upd;
    end
    if (acc && patch) begin
      stat_patch_cnt_d = stat_patch_cnt_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      stat_frame_done_q  <= 1'b0;
      stat_frame_bytes_q <= 32'd0;
      stat_patch_cnt_q   <= 16'd0;
    end else begin
      stat_frame_done_q  <= stat_frame_done_d;
      stat_frame_bytes_q <= stat_frame_bytes_d;
      stat_patch_cnt_q   <= stat_patch_cnt_d;
    end
  end

  assign stat_frame_done  = stat_frame_done_q;
  assign stat_frame_bytes = stat_frame_bytes_q;
  assign stat_patch_cnt   = stat_patch_cnt_q;
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_ob_ftr_fixup.sv
// Bench for cr_xp10_decomp_ob_ftr_fixup: directed frames from the test plan,
// then randomized frames under random backpressure, against a frame-level
// reference model (TLV position, frame byte total, limit flag).

module tb_cr_xp10_decomp_ob_ftr_fixup;

  logic        clk = 1'b0;
  logic        rst_sync_n;
  logic        in_tvalid;
  logic        in_tready;
  logic [63:0] in_tdata;
  logic [7:0]  in_tstrb;
  logic [7:0]  in_tuser;
  logic        in_tid;
  logic        in_tlast;
  logic        out_tvalid;
  logic        out_tready;
  logic [63:0] out_tdata;
  logic [7:0]  out_tstrb;
  logic [7:0]  out_tuser;
  logic        out_tid;
  logic        out_tlast;
  logic        sw_bypass;
  logic [23:0] sw_olimit;
  logic        olimit_err;
`ifdef CR_XP10_DECOMP_OB_FTR_STATS_EN
  logic        stat_frame_done;
  logic [31:0] stat_frame_bytes;
  logic [15:0] stat_patch_cnt;
`endif

  always #5 clk = ~clk;

  cr_xp10_decomp_ob_ftr_fixup dut (
    .clk        (clk),
    .rst_sync_n (rst_sync_n),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tdata   (in_tdata),
    .in_tstrb   (in_tstrb),
    .in_tuser   (in_tuser),
    .in_tid     (in_tid),
    .in_tlast   (in_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tstrb  (out_tstrb),
    .out_tuser  (out_tuser),
    .out_tid    (out_tid),
    .out_tlast  (out_tlast),
    .sw_bypass  (sw_bypass),
    .sw_olimit  (sw_olimit),
    .olimit_err (olimit_err)
`ifdef CR_XP10_DECOMP_OB_FTR_STATS_EN
    ,
    .stat_frame_done  (stat_frame_done),
    .stat_frame_bytes (stat_frame_bytes),
    .stat_patch_cnt   (stat_patch_cnt)
`endif
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic [7:0]  u;
    logic        id;
    logic        last;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [63:0] out_log[$];
  int          n_in = 0;
  int          olim_pulses = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  bit          rdy_chk_en = 0;
  bit          lat_chk = 0;
  bit          gap_en = 0;

  // Reference model state: position in current TLV, its type, frame byte total, limit flag
  int          m_pos;
  logic [7:0]  m_type;
  longint      m_total;
  bit          m_flagged;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_type = 8'h00;
    m_total = 0;
    m_flagged = 0;
  endtask

  task automatic model_accept(input logic [63:0] d, input logic [7:0] s, input logic [7:0] u,
                              input logic id, input logic last, output exp_t e, output bit err);
    bit sot = u[0];
    bit eot = u[1];
    if (sot) begin
      m_pos = 0;
      m_type = d[7:0];
    end else if (m_pos < 15) begin
      m_pos++;
    end
    if (m_type == 8'h0C && m_pos > 0) begin
      m_total += $countones(s);
      if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
    end
    e.d = d; e.s = s; e.u = u; e.id = id; e.last = last;
    if (m_type == 8'h0F && m_pos == 12 && !sw_bypass && !(sot && eot))
      e.d[63:32] = m_total[31:0];
    err = (sw_olimit != 0) && (m_total > longint'(sw_olimit)) && !m_flagged;
    if (err) m_flagged = 1;
    if (m_type == 8'h0F && eot) begin
      m_total = 0;
      m_flagged = 0;
    end
  endtask

  // Called at a negedge; returns at a negedge after the word is accepted
  task automatic send_word(input logic [63:0] d, input logic [7:0] s, input logic [7:0] u,
                           input logic id, input logic last);
    bit   acc = 0;
    int   budget = 0;
    exp_t e;
    bit   err;
    in_tvalid = 1'b1;
    in_tdata = d; in_tstrb = s; in_tuser = u; in_tid = id; in_tlast = last;
    while (!acc) begin
      acc = in_tready;
      @(posedge clk);
      if (acc) begin
        model_accept(d, s, u, id, last, e, err);
        exp_q.push_back(e);
        n_in++;
      end
      @(negedge clk);
      if (acc) begin
        check_eq("olimit_err", olimit_err, err);
        if (lat_chk) begin
          check_eq("lat_valid", out_tvalid, 1);
          check_eq("lat_data", out_tdata, e.d);
        end
      end else if (++budget > 200) begin
        check_eq("accept_timeout", 0, 1);
        break;
      end
    end
    in_tvalid = 1'b0;
    if (gap_en && $urandom_range(0, 7) == 0) @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] rand_user(input bit sot, input bit eot);
    logic [7:0] u;
    u = 8'($urandom);
    u[0] = sot;
    u[1] = eot;
    return u;
  endfunction

  task automatic send_tlv(input logic [7:0] typ, input int nfull, input logic [7:0] last_strb);
    logic [7:0] strb_q[$];
    logic [63:0] d;
    for (int i = 0; i < nfull; i++) strb_q.push_back(8'hFF);
    if (last_strb != 8'h00) strb_q.push_back(last_strb);
    d = {$urandom, $urandom};
    d[7:0] = typ;
    send_word(d, 8'hFF, rand_user(1, strb_q.size() == 0), 1'($urandom), 1'b0);
    for (int i = 0; i < strb_q.size(); i++)
      send_word({$urandom, $urandom}, strb_q[i], rand_user(0, i == strb_q.size() - 1),
                1'($urandom), 1'b0);
  endtask

  task automatic send_ftr(input logic [63:0] w12, input int nwords, output int k12);
    logic [63:0] d;
    k12 = -1;
    for (int i = 0; i < nwords; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) d[7:0] = 8'h0F;
      if (i == 12) begin
        d = w12;
        k12 = n_in;
      end
      send_word(d, 8'hFF, rand_user(i == 0, i == nwords - 1), 1'($urandom), i == nwords - 1);
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check_eq("drain", 64'(exp_q.size()), 0);
    idle(2);
  endtask

  task automatic do_reset();
    rst_sync_n = 1'b0;
    rdy_chk_en = 0;
    #1;
    check_eq("rst_out_tvalid", out_tvalid, 0);
    check_eq("rst_in_tready", in_tready, 0);
    check_eq("rst_out_tdata", out_tdata, 0);
    check_eq("rst_out_ctrl", {out_tstrb, out_tuser, out_tid, out_tlast}, 0);
    check_eq("rst_olimit_err", olimit_err, 0);
    exp_q.delete();
    model_reset();
    n_in = out_log.size();
    repeat (3) @(negedge clk);
    rst_sync_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("post_rst_in_tready", in_tready, 1);
    rdy_chk_en = 1;
  endtask

  // Output side: drive out_tready, score accepted words, check stall stability
  logic [63:0] prev_d;
  logic [17:0] prev_c;
  bit          prev_stall = 0;
  always @(negedge clk) begin
    if (!rst_sync_n) begin
      prev_stall = 0;
      out_tready = 1'b0;
    end else begin
      case (rdy_mode)
        0:       out_tready = 1'b1;
        1:       out_tready = 1'($urandom_range(0, 1));
        default: out_tready = 1'b0;
      endcase
      if (olimit_err) olim_pulses++;
      if (prev_stall) begin
        check_eq("stall_hold_data", out_tdata, prev_d);
        check_eq("stall_hold_ctrl", 64'({out_tstrb, out_tuser, out_tid, out_tlast}), 64'(prev_c));
        check_eq("stall_hold_valid", out_tvalid, 1);
      end
      if (rdy_chk_en && !in_tready) check_eq("rdy_low_skid", out_tvalid, 1);
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 0, 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("out_data", out_tdata, e.d);
          check_eq("out_ctrl", 64'({out_tstrb, out_tuser, out_tid, out_tlast}),
                   64'({e.s, e.u, e.id, e.last}));
        end
        out_log.push_back(out_tdata);
      end
      prev_stall = out_tvalid && !out_tready;
      prev_d = out_tdata;
      prev_c = {out_tstrb, out_tuser, out_tid, out_tlast};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, k_a, k_b, p0, start;
    rst_sync_n = 1'b0;
    in_tvalid = 1'b0; in_tdata = '0; in_tstrb = '0; in_tuser = '0; in_tid = 1'b0; in_tlast = 1'b0;
    sw_bypass = 1'b0; sw_olimit = 24'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 28-byte frame, patched footer, 1-cycle latency with out_tready held high
    rdy_mode = 0; lat_chk = 1;
    send_tlv(8'h0C, 3, 8'h0F);
    send_ftr(64'h0000_0000_0000_1234, 14, k);
    wait_drain();
    check_eq("tp1_w12", out_log[k], 64'h0000_001C_0000_1234);

    // Same stream with bypass
    sw_bypass = 1'b1;
    send_tlv(8'h0C, 3, 8'h0F);
    send_ftr(64'h0000_0000_0000_1234, 14, k);
    wait_drain();
    check_eq("bypass_w12", out_log[k], 64'h0000_0000_0000_1234);
    sw_bypass = 1'b0; lat_chk = 0;

    // Output limit 20: 28, 16, 28 byte frames
    sw_olimit = 24'd20;
    p0 = olim_pulses;
    send_tlv(8'h0C, 3, 8'h0F); send_ftr(64'h0, 14, k); wait_drain();
    check_eq("olim_frame_a", 64'(olim_pulses - p0), 1);
    p0 = olim_pulses;
    send_tlv(8'h0C, 2, 8'h00); send_ftr(64'h0, 14, k); wait_drain();
    check_eq("olim_frame_b", 64'(olim_pulses - p0), 0);
    p0 = olim_pulses;
    send_tlv(8'h0C, 3, 8'h0F); send_ftr(64'h0, 14, k); wait_drain();
    check_eq("olim_frame_c", 64'(olim_pulses - p0), 1);
    sw_olimit = 24'd0;

    // Back-to-back 16 and 40 byte frames
    rdy_mode = 1;
    send_tlv(8'h0C, 2, 8'h00); send_ftr(64'hABCD_0000_0000_0010, 14, k_a);
    send_tlv(8'h0C, 5, 8'h00); send_ftr(64'hABCD_0000_0000_0028, 14, k_b);
    wait_drain();
    check_eq("b2b_16", 64'(out_log[k_a][63:32]), 64'h10);
    check_eq("b2b_40", 64'(out_log[k_b][63:32]), 64'h28);

    // Reset mid-DATA TLV with both buffer entries occupied
    rdy_mode = 2;
    idle(2);
    send_word({56'h0, 8'h0C}, 8'hFF, rand_user(1, 0), 1'b0, 1'b0);
    send_word({$urandom, $urandom}, 8'hFF, rand_user(0, 0), 1'b0, 1'b0);
    check_eq("skid_full_rdy", in_tready, 0);
    do_reset();
    rdy_mode = 1;
    send_word({$urandom, $urandom}, 8'hFF, rand_user(0, 0), 1'b0, 1'b0);
    send_word({$urandom, $urandom}, 8'hFF, rand_user(0, 1), 1'b0, 1'b0);
    send_tlv(8'h0C, 1, 8'h00);
    send_ftr(64'h0000_0000_0000_0055, 14, k);
    wait_drain();
    check_eq("post_rst_w12", out_log[k], 64'h0000_0008_0000_0055);

    // Randomized frames under random backpressure
    gap_en = 1;
    start = n_in;
    while (n_in < start + 1000) begin
      sw_bypass = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       sw_olimit = 24'd0;
        1:       sw_olimit = 24'($urandom_range(1, 40));
        default: sw_olimit = 24'($urandom_range(41, 200));
      endcase
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 3) == 0) send_tlv(8'h05, $urandom_range(0, 3), 8'hFF);
        else send_tlv(8'h0C, $urandom_range(0, 5), 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 7) == 0) send_ftr(64'h0, 1, k);
      send_ftr({$urandom, $urandom}, 14, k);
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_xp10_decomp_ob_ftr_fixup.md
Name: cr_xp10_decomp_ob_ftr_fixup

Overview:
- Output-side stage directly downstream of the XP10 decompressor core, ahead of the decomp regfile output mux.
- Registered AXI4-stream pipeline stage with a 2-entry skid buffer.
- Counts decompressed payload bytes of DATA TLVs per frame and overwrites the bytes_out field in FTR TLV word 12 with the counted value.
- Flags frames whose decompressed size exceeds the software output limit.

Parameters:
- DATA_W, 64: tdata width in bits; tstrb width is DATA_W/8.
- TLV_DATA_TYPE, 8'h0C: TLV type code identifying DATA TLVs, carried in tdata[7:0] of the first TLV word.
- TLV_FTR_TYPE, 8'h0F: TLV type code identifying FTR TLVs.
- FTR_PATCH_WORD, 12: word index within the FTR TLV that carries bytes_in in [31:0] and bytes_out in [63:32].

Ports:
- clk  in  1  clock
- rst_sync_n  in  1  reset, asynchronous, active-low
- in_tvalid  in  1  upstream valid
- in_tready  out  1  upstream ready
- in_tdata  in  DATA_W  data
- in_tstrb  in  DATA_W/8  byte strobes
- in_tuser  in  8  [0]=start of TLV, [1]=end of TLV, others passed through
- in_tid  in  1  stream id, passed through
- in_tlast  in  1  passed through
- out_tvalid  out  1  downstream valid
- out_tready  in  1  downstream ready
- out_tdata  out  DATA_W  data, possibly patched
- out_tstrb  out  DATA_W/8  strobes
- out_tuser  out  8  user
- out_tid  out  1  id
- out_tlast  out  1  last
- sw_bypass  in  1  1 = never patch; counting and limit check still run
- sw_olimit  in  24  output limit in bytes; 0 = limit disabled
- olimit_err  out  1  one-cycle pulse when a frame first exceeds sw_olimit

Behaviour:
- Reset values: in_tready=0 during reset and 1 in the first cycle after reset. out_tvalid=0, all out_* data fields 0, olimit_err=0. Byte counter, word index and TLV-type register are all 0.
- Accept: a word is accepted when in_tvalid && in_tready. All tracking updates happen on accepted words only.
- Skid buffer:
  - Main register plus one skid register.
  - in_tready = !skid_full; it is a registered signal.
  - Latency input to output is 1 cycle; full throughput when out_tready is held high.
  - When out_tready drops, one extra in-flight word is captured into the skid register.
  - The skid register drains before any new input is taken.
- Words are never dropped, duplicated or reordered.
- Word tracking:
  - On accept with in_tuser[0]=1: word_idx resets to 0 for that word, and cur_type latches in_tdata[7:0].
  - On every other accept, word_idx increments and saturates at 15.
- Byte count:
  - Applies to accepted words with cur_type==TLV_DATA_TYPE and word_idx>=1.
  - byte_cnt += popcount(in_tstrb).
  - byte_cnt is 32 bits and saturates at 32'hFFFF_FFFF; no wrap.
- Patch:
  - Condition: accepted word with cur_type==TLV_FTR_TYPE, word_idx==FTR_PATCH_WORD and sw_bypass==0.
  - Action: the stored tdata[63:32] is replaced by byte_cnt, where byte_cnt already includes any same-cycle update (none occurs, since this is an FTR word). All other bits pass unchanged.
- Frame end: on accept of the FTR TLV word with in_tuser[1]=1, byte_cnt clears to 0 and the limit-armed flag re-arms.
- Simultaneous events: if a TLV start and an FTR end occur on the same word (a single-word FTR TLV), the clear takes priority and no patch occurs.
- Limit check:
  - When sw_olimit!=0, byte_cnt after update > sw_olimit, and the flag is armed: olimit_err pulses for 1 cycle and the flag disarms until frame end.
  - Data is not modified by a limit violation.
- Reset mid-frame: all state clears and both buffer entries are discarded. The first word after reset is treated as start-of-stream; any partial TLV that arrives before the next start of TLV is passed through without patching.
- Backpressure: in_tdata, in_tuser and the other inputs need only be stable while valid and not accepted. The outputs hold stable while out_tvalid && !out_tready.

Optional Feature:
- Macro: CR_XP10_DECOMP_OB_FTR_STATS_EN.
- When defined, three extra outputs are added:
  - stat_frame_done (1 bit, pulse at frame end)
  - stat_frame_bytes (32 bits, byte_cnt value held from frame end until the next frame end)
  - stat_patch_cnt (16 bits, wrapping count of patched footers)
- All three reset to 0.
- When not defined, these ports and their logic are absent; the remaining behaviour is identical.

Test Plan:
- DATA TLV of header plus 3 full words, then one word with tstrb=8'h0F, then an FTR TLV of 14 words whose word 12 = 64'h0000_0000_0000_1234 -> output word 12 = 64'h0000_001C_0000_1234, all other words bit-identical, latency 1 cycle.
- Same stream with sw_bypass=1 -> word 12 unchanged at 64'h...1234; output otherwise identical.
- Random out_tready toggling (50%) over 1000 words -> no loss, duplication or reorder; in_tready low only while the skid entry is occupied; output stable while stalled.
- sw_olimit=24'd20 with 28 DATA bytes in one frame -> single olimit_err pulse on the accept that crosses 20; no second pulse in that frame; pulses again in the next frame only if it also exceeds.
- Two back-to-back frames of 16 and 40 bytes -> patched values 0x10 and 0x28; count clears between frames.
- Assert rst_sync_n mid-DATA TLV with both buffer entries full -> out_tvalid=0 immediately, byte_cnt=0. After release, a complete 8-byte frame patches bytes_out=8.
